// File: rtl/redcim_pkg.sv
// Shared types for the ReDCIM engine arbiter: BF16 width, control FSM states
// and the in-flight tag carried alongside each engine operation.
package redcim_pkg;

  localparam int BF16_W   = 16;
  // Tag ID field is sized for up to 256 requesters; the top narrows it to ID_W.
  localparam int TAG_ID_W = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first asserted request at or after the pointer
// wins; the pointer moves just past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_any
);

  logic [ID_W-1:0] ptr_r;

  // Scan requesters starting at the pointer, wrapping, and take the first hit
  always_comb begin
    int   base_s;
    int   idx_s;
    logic hit_s;
    grant     = {NREQ{1'b0}};
    grant_idx = {ID_W{1'b0}};
    grant_any = 1'b0;
    base_s    = 0;
    idx_s     = 0;
    hit_s     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      base_s     = int'(ptr_r) + i;
      idx_s      = (base_s >= NREQ) ? (base_s - NREQ) : base_s;
      hit_s      = req[idx_s] && !grant_any;
      grant[idx_s] = grant[idx_s] | hit_s;
      grant_idx  = hit_s ? ID_W'(idx_s) : grant_idx;
      grant_any  = grant_any | hit_s;
    end
  end

  // Winner becomes lowest priority next time; pointer holds when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= {ID_W{1'b0}};
    end else if (advance) begin
      ptr_r <= (grant_idx == ID_W'(NREQ - 1)) ? {ID_W{1'b0}} : (grant_idx + ID_W'(1));
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/redcim_arbiter.sv
// Shares one pipelined BF16 dot-product engine among NREQ requesters:
// round-robin issue, tag pipeline matching results to owners, halt/drain FSM.
module redcim_arbiter
  import redcim_pkg::*;
#(
  parameter int SIZE    = 2,
  parameter int NREQ    = 2,
  parameter int LATENCY = 3,
  parameter int ID_W    = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*BF16_W*SIZE-1:0] req_A,
  input  logic [NREQ*BF16_W*SIZE-1:0] req_B,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [BF16_W-1:0]         rsp_data,
  output logic                      eng_start,
  output logic [BF16_W*SIZE-1:0]    eng_A,
  output logic [BF16_W*SIZE-1:0]    eng_B,
  input  logic [BF16_W-1:0]         eng_out,
  input  logic                      halt,
  output logic                      busy
);

  localparam int OP_W = BF16_W * SIZE;

  state_e            state_r;
  state_e            state_s;
  logic              run_ok_s;
  logic [NREQ-1:0]   req_gated_s;
  logic [NREQ-1:0]   grant_s;
  logic [ID_W-1:0]   grant_idx_s;
  logic              grant_any_s;
  logic              tags_busy_s;

  logic              eng_start_r;
  logic [OP_W-1:0]   eng_a_r;
  logic [OP_W-1:0]   eng_b_r;
  logic [ID_W-1:0]   eng_id_r;
  tag_t              tag_r [LATENCY];

  logic              rsp_valid_r;
  logic [ID_W-1:0]   rsp_id_r;
  logic [BF16_W-1:0] rsp_data_r;

  // Requests are only visible to the arbiter while running and not halting,
  // so a halt arriving with a request blocks that request in the same cycle
  always_comb begin
    run_ok_s    = (state_r == RUN) && !halt;
    req_gated_s = req_valid & {NREQ{run_ok_s}};
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_gated_s),
    .advance   (grant_any_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // Any operation still travelling through the engine
  always_comb begin
    tags_busy_s = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      tags_busy_s = tags_busy_s | tag_r[i].valid;
    end
  end

  // Control FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Control FSM next state: halt starts a drain, empty engine parks it
  always_comb begin
    state_s = state_r;
    case (state_r)
      RUN: begin
        if (halt) state_s = DRAIN;
        else      state_s = RUN;
      end
      DRAIN: begin
        if (!halt)             state_s = RUN;
        else if (!tags_busy_s) state_s = HALTED;
        else                   state_s = DRAIN;
      end
      HALTED: begin
        if (!halt) state_s = RUN;
        else       state_s = HALTED;
      end
      default: state_s = RUN;
    endcase
  end

  // Register the granted operands for issue; operands hold between issues
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eng_start_r <= 1'b0;
      eng_a_r     <= {OP_W{1'b0}};
      eng_b_r     <= {OP_W{1'b0}};
      eng_id_r    <= {ID_W{1'b0}};
    end else if (grant_any_s) begin
      eng_start_r <= 1'b1;
      eng_a_r     <= req_A[grant_idx_s*OP_W +: OP_W];
      eng_b_r     <= req_B[grant_idx_s*OP_W +: OP_W];
      eng_id_r    <= grant_idx_s;
    end else begin
      eng_start_r <= 1'b0;
    end
  end

  // Tag pipeline: the last stage lines up with valid engine output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_r[i] <= '{valid: 1'b0, id: {TAG_ID_W{1'b0}}};
      end
    end else begin
      tag_r[0] <= '{valid: eng_start_r, id: TAG_ID_W'(eng_id_r)};
      for (int i = 1; i < LATENCY; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Capture the engine result with its owner for a one-cycle response strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {ID_W{1'b0}};
      rsp_data_r  <= {BF16_W{1'b0}};
    end else if (tag_r[LATENCY-1].valid) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= ID_W'(tag_r[LATENCY-1].id);
      rsp_data_r  <= eng_out;
    end else begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign req_ready = grant_s;
  assign eng_start = eng_start_r;
  assign eng_A     = eng_a_r;
  assign eng_B     = eng_b_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = tags_busy_s | eng_start_r | rsp_valid_r | (state_r == DRAIN);

endmodule
